// File: rtl/map_pkg.sv
// Shared map-ROM definitions: map geometry, owner tags for returning read data,
// and the probe wait-counter step used for starvation tracking.
package map_pkg;

    localparam int MAP_ADDR_W = 12;
    localparam int MAP_W      = 70;
    localparam int MAP_H      = 50;
    localparam int WAIT_W     = 10;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_P0   = 2'd2,
        TAG_P1   = 2'd3
    } owner_tag_t;

    // Wait counter clears whenever the probe is idle or served, and saturates.
    function automatic logic [WAIT_W-1:0] wait_next(
        input logic [WAIT_W-1:0] cnt,
        input logic              req,
        input logic              granted
    );
        if (!req || granted) begin
            return '0;
        end
        if (cnt == {WAIT_W{1'b1}}) begin
            return cnt;
        end
        return cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/map_tag_pipe.sv
// Owner-tag delay line matching the ROM read latency; clear empties all stages
// so reads issued before a reset never return.
module map_tag_pipe
    import map_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  owner_tag_t tag_in,
    output owner_tag_t tag_out
);

    owner_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares the single map ROM port between the display path (active video) and
// two round-robin probe requesters (blanking), routing read data back by tag.
module map_rom_arbiter
    import map_pkg::*;
#(
    parameter int                ADDR_W     = MAP_ADDR_W,
    parameter int                DATA_W     = 8,
    parameter int                RD_LAT     = 1,
    parameter logic [WAIT_W-1:0] STARVE_LIM = 10'd1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              blank,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        starved
);

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              rr_ptr;      // 0 = P0 wins a tie, 1 = P1 wins a tie
    owner_tag_t        issue_next;
    owner_tag_t        issue_tag;
    owner_tag_t        ret_tag;
    logic [WAIT_W-1:0] wait0;
    logic [WAIT_W-1:0] wait1;
    logic [WAIT_W-1:0] wait0_next;
    logic [WAIT_W-1:0] wait1_next;

    // A probe in its ack cycle is not eligible, so one requester gets at most every other slot.
    assign elig0 = p0_req && !p0_ack;
    assign elig1 = p1_req && !p1_ack;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        issue_next = TAG_NONE;
        if (!blank) begin
            issue_next = TAG_DISP;
        end else begin
            if (elig0 && elig1) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
            if (grant0) begin
                issue_next = TAG_P0;
            end else if (grant1) begin
                issue_next = TAG_P1;
            end
        end
    end

    assign wait0_next = wait_next(wait0, p0_req, grant0);
    assign wait1_next = wait_next(wait1, p1_req, grant1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            rr_ptr    <= 1'b0;
            issue_tag <= TAG_NONE;
        end else begin
            p0_ack    <= grant0;
            p1_ack    <= grant1;
            issue_tag <= issue_next;
            if (!blank) begin
                rom_addr <= disp_addr;
            end else if (grant0) begin
                rom_addr <= p0_addr;
            end else if (grant1) begin
                rom_addr <= p1_addr;
            end
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // issue_tag is aligned with rom_addr; the pipe adds the ROM's own latency.
    map_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset_n),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_data  <= '0;
            disp_valid <= 1'b0;
            p0_rdata   <= '0;
            p0_rvalid  <= 1'b0;
            p1_rdata   <= '0;
            p1_rvalid  <= 1'b0;
        end else begin
            disp_valid <= (ret_tag == TAG_DISP);
            p0_rvalid  <= (ret_tag == TAG_P0);
            p1_rvalid  <= (ret_tag == TAG_P1);
            if (ret_tag == TAG_DISP) begin
                disp_data <= rom_data;
            end
            if (ret_tag == TAG_P0) begin
                p0_rdata <= rom_data;
            end
            if (ret_tag == TAG_P1) begin
                p1_rdata <= rom_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait0   <= '0;
            wait1   <= '0;
            starved <= 2'b00;
        end else begin
            wait0      <= wait0_next;
            wait1      <= wait1_next;
            starved[0] <= starved[0] | (wait0_next >= STARVE_LIM);
            starved[1] <= starved[1] | (wait1_next >= STARVE_LIM);
        end
    end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter: display path, blocked probes, contention,
// blank edges with reads in flight, starvation and async reset.
module tb_map_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        blank;
    logic [11:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        p0_req;
    logic [11:0] p0_addr;
    logic        p0_ack;
    logic [7:0]  p0_rdata;
    logic        p0_rvalid;
    logic        p1_req;
    logic [11:0] p1_addr;
    logic        p1_ack;
    logic [7:0]  p1_rdata;
    logic        p1_rvalid;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  starved;

    int checks = 0;
    int errors = 0;

    map_rom_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .blank      (blank),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_ack     (p0_ack),
        .p0_rdata   (p0_rdata),
        .p0_rvalid  (p0_rvalid),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_ack     (p1_ack),
        .p1_rdata   (p1_rdata),
        .p1_rvalid  (p1_rvalid),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .starved    (starved)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous ROM whose content is the low address byte.
    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        blank     = 1'b0;
        disp_addr = '0;
        p0_req    = 1'b0;
        p0_addr   = '0;
        p1_req    = 1'b0;
        p1_addr   = '0;
        #2;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'h0);
        chk("rst_valids", {29'd0, disp_valid, p0_rvalid, p1_rvalid}, 32'h0);
        chk("rst_data", {8'd0, disp_data, p0_rdata, p1_rdata}, 32'h0);
        chk("rst_starved", 32'(starved), 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        blank   = 1'b1;
        tick();

        // Display only: single active-video cycle at 0x123
        blank     = 1'b0;
        disp_addr = 12'h123;
        tick();
        chk("disp_rom_addr", 32'(rom_addr), 32'h123);
        chk("disp_no_ack", {30'd0, p0_ack, p1_ack}, 32'h0);
        chk("disp_valid_early0", 32'(disp_valid), 32'h0);
        blank = 1'b1;
        tick();
        chk("disp_valid_early1", 32'(disp_valid), 32'h0);
        tick();
        chk("disp_valid", 32'(disp_valid), 32'h1);
        chk("disp_data", 32'(disp_data), 32'h23);
        tick();
        chk("disp_valid_pulse", 32'(disp_valid), 32'h0);
        chk("disp_data_hold", 32'(disp_data), 32'h23);

        // Probe blocked by active video, then served in blanking
        blank     = 1'b0;
        disp_addr = 12'h055;
        p0_req    = 1'b1;
        p0_addr   = 12'h0AF;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("blocked_no_ack", {30'd0, p0_ack, p1_ack}, 32'h0);
        end
        blank = 1'b1;
        tick();
        chk("p0_ack", 32'(p0_ack), 32'h1);
        chk("p0_rom_addr", 32'(rom_addr), 32'h0AF);
        p0_req = 1'b0;
        tick();
        chk("p0_ack_pulse", 32'(p0_ack), 32'h0);
        chk("p0_rvalid_early", 32'(p0_rvalid), 32'h0);
        chk("disp_inflight_valid", 32'(disp_valid), 32'h1);
        chk("disp_inflight_data", 32'(disp_data), 32'h55);
        tick();
        chk("p0_rvalid", 32'(p0_rvalid), 32'h1);
        chk("p0_rdata", 32'(p0_rdata), 32'hAF);
        tick();
        chk("p0_rvalid_pulse", 32'(p0_rvalid), 32'h0);

        // Blank falls while a p1 read is in flight
        p1_req    = 1'b1;
        p1_addr   = 12'h3FF;
        disp_addr = 12'h234;
        tick();
        chk("p1_ack", 32'(p1_ack), 32'h1);
        chk("p1_rom_addr", 32'(rom_addr), 32'h3FF);
        p1_req = 1'b0;
        blank  = 1'b0;
        tick();
        chk("edge_rom_addr", 32'(rom_addr), 32'h234);
        chk("edge_p1_ack_pulse", 32'(p1_ack), 32'h0);
        disp_addr = 12'h2AB;
        tick();
        chk("edge_p1_rvalid", 32'(p1_rvalid), 32'h1);
        chk("edge_p1_rdata", 32'(p1_rdata), 32'hFF);
        chk("edge_no_disp_valid", 32'(disp_valid), 32'h0);
        chk("edge_p0_rdata_hold", 32'(p0_rdata), 32'hAF);
        tick();
        chk("edge_disp_valid0", 32'(disp_valid), 32'h1);
        chk("edge_disp_data0", 32'(disp_data), 32'h34);
        chk("edge_p1_rvalid_pulse", 32'(p1_rvalid), 32'h0);
        blank = 1'b1;
        tick();
        chk("edge_disp_valid1", 32'(disp_valid), 32'h1);
        chk("edge_disp_data1", 32'(disp_data), 32'hAB);

        // Contention: pointer names P0 after the last p1 grant
        p0_req  = 1'b1;
        p0_addr = 12'h010;
        p1_req  = 1'b1;
        p1_addr = 12'h020;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rr_p0_ack", 32'(p0_ack), 32'(k % 2 == 1));
            chk("rr_p1_ack", 32'(p1_ack), 32'(k % 2 == 0));
            chk("rr_p0_rvalid", 32'(p0_rvalid), 32'(k >= 3 && k % 2 == 1));
            chk("rr_p1_rvalid", 32'(p1_rvalid), 32'(k >= 4 && k % 2 == 0));
            if (k >= 3) begin
                chk("rr_p0_rdata", 32'(p0_rdata), 32'h10);
            end
            if (k >= 4) begin
                chk("rr_p1_rdata", 32'(p1_rdata), 32'h20);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        chk("rr_flush_p0_rvalid", 32'(p0_rvalid), 32'h1);
        tick();
        chk("rr_flush_p1_rvalid", 32'(p1_rvalid), 32'h1);
        tick();
        chk("rr_idle_acks", {30'd0, p0_ack, p1_ack}, 32'h0);

        // Starvation of p0 under permanent active video
        blank   = 1'b0;
        p0_req  = 1'b1;
        p0_addr = 12'h0C3;
        for (int i = 0; i < 1022; i++) begin
            tick();
        end
        chk("starve_before_lim", 32'(starved), 32'h0);
        tick();
        chk("starve_at_lim", 32'(starved), 32'h1);
        blank = 1'b1;
        tick();
        chk("starve_served_ack", 32'(p0_ack), 32'h1);
        chk("starve_sticky0", 32'(starved), 32'h1);
        p0_req = 1'b0;
        tick();
        tick();
        chk("starve_served_rvalid", 32'(p0_rvalid), 32'h1);
        chk("starve_served_rdata", 32'(p0_rdata), 32'hC3);
        chk("starve_sticky1", 32'(starved), 32'h1);

        // Async reset with a p1 read in flight
        p1_req  = 1'b1;
        p1_addr = 12'h3FF;
        tick();
        chk("rst_pre_p1_ack", 32'(p1_ack), 32'h1);
        #2;
        reset_n = 1'b0;
        p1_req  = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(rom_addr), 32'h0);
        chk("arst_acks", {30'd0, p0_ack, p1_ack}, 32'h0);
        chk("arst_valids", {29'd0, disp_valid, p0_rvalid, p1_rvalid}, 32'h0);
        chk("arst_data", {8'd0, disp_data, p0_rdata, p1_rdata}, 32'h0);
        chk("arst_starved", 32'(starved), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_rvalid", {29'd0, disp_valid, p0_rvalid, p1_rvalid}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Shares the single map ROM port (12-bit address, one read per clock) between the display address path and two game-logic probe requesters (player collision, enemy AI).
- The display path owns the ROM whenever blank=0. Probes are served only during blanking, with round-robin between them.
- Read data is routed back to its owner using a tag pipeline matched to the ROM read latency.

Parameters:
- ADDR_W, 12, map ROM address width.
- DATA_W, 8, map ROM data width.
- RD_LAT, 1, ROM cycles from address register to valid rom_data (1..4).
- STARVE_LIM, 1023, cycles a probe may wait with req high before its starved bit sets.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- blank  in  1  display blanking; 0 = display owns ROM this cycle
- disp_addr  in  ADDR_W  display pixel address (already 0 when out of sprite bounds)
- disp_data  out  DATA_W  ROM data for display
- disp_valid  out  1  disp_data valid
- p0_req / p1_req  in  1  probe read request, held until ack
- p0_addr / p1_addr  in  ADDR_W  probe address, stable while req high
- p0_ack / p1_ack  out  1  one-cycle pulse: request issued to ROM
- p0_rdata / p1_rdata  out  DATA_W  probe read data
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse: rdata valid
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM read data
- starved  out  2  sticky per-probe starvation flags

Behaviour:
- Reset (async, reset_n=0):
  - rom_addr=0, all acks/rvalids/disp_valid=0, all data outputs=0, starved=0.
  - Tag pipe cleared to NONE; round-robin pointer = P0; wait counters=0.
- Issue decision, evaluated at every rising edge from the sampled inputs:
  - blank=0: rom_addr<=disp_addr, tag DISP issued. No probe ack that cycle, whatever req is.
  - blank=1: eligible probe = pN_req && !pN_ack. A probe is never re-granted in its own ack cycle, so the minimum spacing for one requester is 2 cycles.
    - One eligible: grant it.
    - Both eligible: grant the one the pointer names, then point the pointer at the other.
    - Single grant: pointer moves to the non-granted probe.
  - Grant actions: rom_addr<=pN_addr, pN_ack<=1 for one cycle, tag PN issued.
  - blank=1 with nothing eligible: rom_addr holds its value, tag NONE.
- Tag pipe:
  - Depth RD_LAT shift register of 2-bit owner tags, advancing every cycle.
  - At the edge RD_LAT+1 after issue, rom_data is registered into the owner's data output and the owner's valid pulses for one cycle.
  - Non-owner data outputs hold their last value.
- Latency, fixed and deterministic: valid/rvalid rises RD_LAT+1 edges after the edge that registered the address or raised the ack. RD_LAT=1 gives 2 cycles.
- blank transitions:
  - Display data already in flight completes even if blank rises.
  - Probe reads in flight complete even if blank falls.
  - Data is never dropped or reordered.
- Starvation:
  - Per-probe 10-bit wait counter increments each cycle with req=1 and no ack; it clears on ack or req=0 and saturates.
  - Reaching STARVE_LIM sets starved[n], which stays set until reset.
- Reset mid-operation: in-flight tags are discarded. No valid/rvalid pulses occur after reset_n rises for reads issued before reset.
- Width rules: addresses are passed through unmodified. No arithmetic on the address or data path.

Decomposition:
- Shared package map_pkg holds:
  - MAP_ADDR_W=12, MAP_W=70, MAP_H=50;
  - owner tag encoding TAG_NONE=0, TAG_DISP=1, TAG_P0=2, TAG_P1=3.
- One sub-module, map_tag_pipe: RD_LAT-deep tag shift register with async active-low clear, taking a tag in and giving the delayed tag out.

Test Plan:
- Display only: blank=0, disp_addr=0x123, ROM model returns addr[7:0] -> disp_valid=1 with disp_data=0x23 exactly 2 cycles after the edge that sampled it; no acks.
- Probe blocked: blank=0, p0_req=1 (addr 0x0AF) for 20 cycles, then blank=1 -> no p0_ack while blank=0; p0_ack one cycle after blank=1 sampled; p0_rvalid 2 cycles later with data 0xAF.
- Contention: blank=1, p0_req and p1_req both held with addrs 0x010 and 0x020 -> acks alternate P0, P1, P0 ...; no ack on consecutive cycles for the same probe; rdata order matches ack order.
- Blank edge in flight: issue p1 read at 0x3FF, drop blank on the next cycle -> p1_rvalid still pulses with 0xFF; disp_valid resumes on the following cycle with no gap or duplicate.
- Starvation: blank=0 permanently, p0_req=1 -> starved=2'b01 after 1023 cycles; it stays set when blank later rises and p0 is served; cleared only by reset_n=0.
- Async reset: assert reset_n=0 mid-cycle with 1 probe read in flight -> all outputs 0 immediately; after release, no stale rvalid.
